// File: rtl/bip_core.sv
//==============================================================================
// Module   : bip_core
// Purpose  : Parametrised accumulator processor core. A multi-cycle FSM
//            (FETCH / EXEC / MEM / HALT) that drives external program and
//            data memories with synchronous read. It supports immediate,
//            memory and branch instructions, an instruction-boundary run
//            input, a halt status output and retire tracing.
// Options  : BIP_CYCLE_COUNT_EN - when defined, a saturating cycle counter
//            drives cycle_count; otherwise cycle_count is tied to zero.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module bip_core #(
  parameter int AB  = 11,
  parameter int DB  = 16,
  parameter int OPW = 5,
  parameter int CW  = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic [AB-1:0] pm_addr,
  input  logic [DB-1:0] pm_data,
  output logic [AB-1:0] dm_addr,
  output logic          dm_rd,
  input  logic [DB-1:0] dm_rdata,
  output logic          dm_wr,
  output logic [DB-1:0] dm_wdata,
  output logic [DB-1:0] acc,
  output logic          halted,
  output logic          retire,
  output logic [CW-1:0] cycle_count
);

  // Opcode encodings; wider opcode fields keep the upper bits at zero.
  localparam logic [OPW-1:0] c_OP_HLT  = OPW'(0);
  localparam logic [OPW-1:0] c_OP_STO  = OPW'(1);
  localparam logic [OPW-1:0] c_OP_LD   = OPW'(2);
  localparam logic [OPW-1:0] c_OP_LDI  = OPW'(3);
  localparam logic [OPW-1:0] c_OP_ADD  = OPW'(4);
  localparam logic [OPW-1:0] c_OP_ADDI = OPW'(5);
  localparam logic [OPW-1:0] c_OP_SUB  = OPW'(6);
  localparam logic [OPW-1:0] c_OP_SUBI = OPW'(7);
  localparam logic [OPW-1:0] c_OP_BEQ  = OPW'(8);
  localparam logic [OPW-1:0] c_OP_BNE  = OPW'(9);
  localparam logic [OPW-1:0] c_OP_JMP  = OPW'(10);

  // Which accumulator update the MEM state applies to the read data.
  localparam logic [1:0] c_MOP_LD  = 2'd0;
  localparam logic [1:0] c_MOP_ADD = 2'd1;
  localparam logic [1:0] c_MOP_SUB = 2'd2;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t        state_q;
  logic [AB-1:0] pc_q;
  logic [DB-1:0] acc_q;
  logic [AB-1:0] dm_addr_q;
  logic [1:0]    mop_q;
  logic          retire_q;
  logic          halted_q;

  logic [OPW-1:0] w_opcode;
  logic [AB-1:0]  w_operand;
  logic [DB-1:0]  w_imm;
  logic [AB-1:0]  w_pc_inc_d;
  logic           w_in_exec;
  logic           w_rd_op;
  logic           w_st_op;

  // Only the opcode and operand fields of the instruction word are decoded.
  logic unused_pm_bits;
  assign unused_pm_bits = ^pm_data;

  assign w_opcode   = pm_data[DB-1 -: OPW];
  assign w_operand  = pm_data[AB-1:0];
  assign w_imm      = {{(DB-AB){w_operand[AB-1]}}, w_operand};
  assign w_pc_inc_d = pc_q + AB'(1);
  assign w_in_exec  = (state_q == S_EXEC);
  assign w_rd_op    = (w_opcode == c_OP_LD) || (w_opcode == c_OP_ADD) ||
                      (w_opcode == c_OP_SUB);
  assign w_st_op    = (w_opcode == c_OP_STO);

  // Memory strobes are decoded straight from the fetched word during EXEC so
  // read data returns in the following (MEM) cycle; the address register
  // keeps the last accessed location between accesses.
  assign dm_rd    = w_in_exec && w_rd_op;
  assign dm_wr    = w_in_exec && w_st_op;
  assign dm_addr  = (dm_rd || dm_wr) ? w_operand : dm_addr_q;
  assign dm_wdata = acc_q;
  assign pm_addr  = pc_q;
  assign acc      = acc_q;
  assign halted   = halted_q;
  assign retire   = retire_q;

  // Main control FSM: sequencing, PC, accumulator and status registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      acc_q     <= '0;
      dm_addr_q <= '0;
      mop_q     <= c_MOP_LD;
      retire_q  <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      retire_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (enable) begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          state_q  <= S_FETCH;
          retire_q <= 1'b1;
          pc_q     <= w_pc_inc_d;
          case (w_opcode)
            c_OP_HLT: begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
              pc_q     <= pc_q;
            end
            c_OP_STO: dm_addr_q <= w_operand;
            c_OP_LD: begin
              dm_addr_q <= w_operand;
              mop_q     <= c_MOP_LD;
              state_q   <= S_MEM;
              retire_q  <= 1'b0;
            end
            c_OP_ADD: begin
              dm_addr_q <= w_operand;
              mop_q     <= c_MOP_ADD;
              state_q   <= S_MEM;
              retire_q  <= 1'b0;
            end
            c_OP_SUB: begin
              dm_addr_q <= w_operand;
              mop_q     <= c_MOP_SUB;
              state_q   <= S_MEM;
              retire_q  <= 1'b0;
            end
            c_OP_LDI:  acc_q <= w_imm;
            c_OP_ADDI: acc_q <= acc_q + w_imm;
            c_OP_SUBI: acc_q <= acc_q - w_imm;
            c_OP_BEQ: begin
              if (acc_q == '0) begin
                pc_q <= w_operand;
              end
            end
            c_OP_BNE: begin
              if (acc_q != '0) begin
                pc_q <= w_operand;
              end
            end
            c_OP_JMP: pc_q <= w_operand;
            default: ;
          endcase
        end
        S_MEM: begin
          state_q  <= S_FETCH;
          retire_q <= 1'b1;
          case (mop_q)
            c_MOP_LD:  acc_q <= dm_rdata;
            c_MOP_ADD: acc_q <= acc_q + dm_rdata;
            default:   acc_q <= acc_q - dm_rdata;
          endcase
        end
        S_HALT: ;
        default: state_q <= S_FETCH;
      endcase
    end
  end

`ifdef BIP_CYCLE_COUNT_EN
  logic [CW-1:0] cycle_q;

  // Saturating count of every non-halted cycle, stalled fetches included.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_q <= '0;
    end else if ((state_q != S_HALT) && (cycle_q != {CW{1'b1}})) begin
      cycle_q <= cycle_q + CW'(1);
    end
  end

  assign cycle_count = cycle_q;
`else
  assign cycle_count = '0;
`endif

endmodule

`default_nettype wire

// File: doc/bip_core.md
Name: bip_core

Overview:
Parametrised accumulator processor core, successor to the fixed-width BIP top level. It merges control and datapath into one multi-cycle FSM with configurable address/data/opcode widths. It adds conditional/unconditional branches, an instruction-boundary run/stall input, a halt status output and retire tracing. Program and data memories stay external, with synchronous read.

Parameters:
AB, 11, address bus width (PC, program and data memory addresses)
DB, 16, data/instruction width
OPW, 5, opcode field width; DB-OPW >= AB required
CW, 32, cycle counter width

Ports:
clk  in  1  clock, all logic rising-edge
reset  in  1  synchronous, active-low reset
enable  in  1  run permission, sampled only in FETCH
pm_addr  out  AB  program memory address (= PC)
pm_data  in  DB  instruction, valid one cycle after pm_addr
dm_addr  out  AB  data memory address
dm_rd  out  1  data memory read strobe
dm_rdata  in  DB  read data, valid one cycle after dm_rd
dm_wr  out  1  data memory write strobe
dm_wdata  out  DB  write data (= ACC)
acc  out  DB  accumulator
halted  out  1  core in HALT
retire  out  1  one-cycle pulse per completed instruction
cycle_count  out  CW  cycles executed since reset (see Optional Feature)

Behaviour:
- Reset (reset=0 at clk edge): PC=0, ACC=0, state=FETCH, dm_rd=dm_wr=retire=halted=0, dm_addr=0, cycle_count=0. Overrides everything, mid-instruction included; a pending memory access is abandoned.
- Instruction fields: opcode=pm_data[DB-1:DB-OPW], operand=pm_data[AB-1:0]; immediate = operand sign-extended to DB.
- States: FETCH, EXEC, MEM, HALT.
  FETCH: pm_addr=PC; enable=1 -> EXEC, else stay (no strobes).
  EXEC: decode pm_data, PC <= PC+1 unless branch taken.
  MEM: ACC updated from dm_rdata -> FETCH.
- Opcodes (OPW=5 encodings, upper bits zero for wider OPW):
  00000 HLT: -> HALT, PC not incremented.
  00001 STO: dm_addr=operand, dm_wr=1 for the EXEC cycle, dm_wdata=ACC.
  00010 LD / 00100 ADD / 00110 SUB: dm_addr=operand, dm_rd=1 in EXEC -> MEM; ACC <= rdata / ACC+rdata / ACC-rdata.
  00011 LDI / 00101 ADDI / 00111 SUBI: ACC <= imm / ACC+imm / ACC-imm in EXEC.
  01000 BEQ: if ACC==0, PC <= operand. 01001 BNE: if ACC!=0, PC <= operand. 01010 JMP: PC <= operand.
  Other codes: NOP (PC+1).
- Latency: immediate/store/branch/NOP 2 cycles; LD/ADD/SUB 3 cycles; HLT 2 cycles to HALT.
- Arithmetic modulo 2^DB, no flags, no saturation.
- PC wraps 2^AB-1 -> 0.
- dm_addr holds the last value between accesses.
- retire pulses on the cycle leaving EXEC (non-memory ops) or MEM (memory ops), including HLT.
- HALT: halted=1, no strobes, enable ignored; exit only via reset.
- Branch condition uses ACC as of the EXEC cycle.

Optional Feature:
BIP_CYCLE_COUNT_EN:
- Defined: cycle_count increments every cycle in FETCH/EXEC/MEM, including stalled FETCH cycles. It freezes in HALT and saturates at 2^CW-1.
- Undefined: cycle_count is constant 0 and the counter register is not synthesised.

Test Plan:
- Program LDI 5; ADDI -2; STO 0x010; HLT -> dm_wr pulse with dm_addr=0x010, dm_wdata=0x0003; halted=1; acc=0x0003; 4 retire pulses; cycle_count=8 with macro, 0 without.
- DM[0x020]=0x7FFF; LD 0x020; ADD 0x020; SUB 0x020 -> acc 0x7FFF, 0xFFFE, 0x7FFF; each instruction 3 cycles; dm_rd asserted one cycle each.
- LDI 0; BEQ 0x005 (taken, pm_addr next fetch=0x005); at 0x005 LDI 1; BNE 0x000 -> loops back to 0x000; JMP 0x7FF then NOP at 0x7FF -> pm_addr wraps to 0x000.
- enable=0 at reset release for 10 cycles -> pm_addr=0, no strobes, no retire; cycle_count=10 with macro. Raise enable -> execution starts next cycle.
- reset=0 asserted in MEM of an ADD -> next cycle PC=0, ACC=0, dm_rd=0, state FETCH; acc not updated from dm_rdata.
- Undefined opcode 11111 at 0x000, then HLT -> one retire for the NOP, acc unchanged, PC=0x001 at HLT decode.
